// File: rtl/rgb_pair_arbiter.sv
// rgb_pair_arbiter: round-robin, burst-locked sharing of one RGB888->YUV422 converter between two pixel sources
module rgb_pair_arbiter #(
  parameter int BURST = 8,
  parameter int CW    = $clog2(BURST)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i0_valid,
  output logic        i0_ready,
  input  logic [23:0] i0_rgb,
  input  logic        i1_valid,
  output logic        i1_ready,
  input  logic [23:0] i1_rgb,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [23:0] o_rgb,
  output logic        o_src,
  output logic        o_first,
  output logic        o_last
);
  if (BURST < 2 || BURST % 2 != 0) begin : g_bad_burst
    $error("BURST must be even and at least 2");
  end
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_n;
  logic prio;
  logic [CW-1:0] cnt;
  logic take, beat, last, src;
  logic [23:0] rgb;
  always_comb begin
    take     = !o_valid || o_ready;
    src      = state == G1;
    rgb      = src ? i1_rgb : i0_rgb;
    i0_ready = state == G0 && take;
    i1_ready = state == G1 && take;
    beat     = (i0_ready && i0_valid) || (i1_ready && i1_valid);
    last     = cnt == CW'(BURST - 1);
    state_n  = state == IDLE ? (i0_valid && i1_valid ? (prio ? G1 : G0) :
                                i0_valid ? G0 : i1_valid ? G1 : IDLE) :
               state == G0 || state == G1 ? (beat && last ? IDLE : state) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_rgb   <= '0;
      o_src   <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      state   <= state_n;
      o_valid <= beat || (o_valid && !o_ready);
      if (beat) begin
        cnt     <= last ? '0 : cnt + CW'(1);
        prio    <= last ? !src : prio;
        o_rgb   <= rgb;
        o_src   <= src;
        o_first <= cnt == '0;
        o_last  <= last;
      end
    end
  end
endmodule

// File: doc/rgb_pair_arbiter.md
# rgb_pair_arbiter

Shares one Rgb888ToYuv422 conversion datapath between two RGB888 pixel sources. Each grant is locked for a fixed burst of pixels, so a YUV422 chroma pair is never split between sources. Accepted pixels pass to the converter through a single registered output stage, tagged with their source. Sources are served round-robin, so neither camera/DMA front end can starve the other.

## Interface
Parameters:
- BURST, 8, pixels per grant; must be even and at least 2; elaboration fails otherwise.
- CW, $clog2(BURST), width of the burst counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i0_valid  in  1  source 0 pixel valid.
- i0_ready  out  1  source 0 pixel accepted when high together with i0_valid.
- i0_rgb  in  24  source 0 pixel: {R[23:16], G[15:8], B[7:0]}.
- i1_valid, i1_ready, i1_rgb  same as source 0, for source 1.
- o_valid  out  1  pixel presented to the converter.
- o_ready  in  1  converter accepts the output pixel.
- o_rgb  out  24  pixel data.
- o_src  out  1  source index of the output pixel.
- o_first  out  1  first pixel of a burst.
- o_last  out  1  last pixel of a burst.

## Operation
- FSM states are IDLE, G0 and G1. Other state: prio (1 bit, the source favoured next) and cnt (CW bits).
- IDLE:
  - Both ix_ready are 0.
  - If exactly one ix_valid is high, go to Gx.
  - If both are high, go to G[prio].
  - If neither is high, stay in IDLE.
- Gx, pixel acceptance:
  - ix_ready = !o_valid || o_ready. The other source's ready is 0.
  - A beat is ix_valid && ix_ready.
  - Each beat loads the output register with {rgb, src = x, first = (cnt == 0), last = (cnt == BURST-1)} and increments cnt.
- Gx, burst end:
  - On the beat with cnt == BURST-1: cnt goes to 0, prio goes to !x, and the FSM goes to IDLE.
- Gx, gaps:
  - The grant stays locked while ix_valid is low. There is no timeout and no preemption.
  - Stalls on o_ready are allowed and hold the grant.
- Output register:
  - o_valid is set on a beat.
  - o_valid is cleared when o_valid && o_ready and there is no new beat in the same cycle.
  - When o_ready and a beat occur in the same cycle, the register is replaced and o_valid stays 1 (full throughput).
- Data stability: o_rgb, o_src, o_first and o_last stay stable while o_valid && !o_ready.
- Counter wrap: cnt never exceeds BURST-1. Bursts are always complete, so the converter always receives an even number of pixels per source run.

## Timing
- Reset values, all while rst = 0:
  - state = IDLE, prio = 0, cnt = 0.
  - o_valid = 0, o_rgb = 0, o_src = 0, o_first = 0, o_last = 0.
  - i0_ready = i1_ready = 0.
- Reset mid-burst aborts the burst immediately. Any partially transferred pair is discarded, and the converter's own reset covers its side.
- Arbitration latency: a valid that appears in IDLE gets ready high on the next cycle. Each burst costs exactly one IDLE bubble cycle.
- Pixel latency: 1 cycle from the input beat to o_valid.
- Sustained throughput with o_ready tied high and both sources always valid: BURST pixels per BURST+1 cycles.
- ix_ready depends combinationally on o_ready. ix_valid must not depend on ix_ready.
- Simultaneous events:
  - A burst-ending beat and the other source's valid in the same cycle: the grant goes to the other source after the IDLE cycle.
  - A source that drops valid while in IDLE is ignored. The decision is made only on the IDLE cycle's values.

## Test plan
- Reset and idle: hold rst = 0 for 3 cycles with both sources valid.
  - Required: all outputs 0 and both readies 0.
  - After release: i0_ready rises on the second cycle (G0 entered).
- Single source, BURST = 8, o_ready = 1: only source 0 valid, sending pixels 0x000001 through 0x000010.
  - Required: 16 outputs in order with o_src = 0.
  - o_first on pixels 1 and 9, o_last on pixels 8 and 16.
  - One bubble after each last pixel.
- Round-robin: both sources always valid.
  - Required: o_src sequence is 8×0, 8×1, 8×0, 8×1.
  - prio alternates, and there is no back-to-back burst from the same source.
- Backpressure: drive o_ready in a 1-0-0-1 pattern during a G1 burst.
  - Required: no pixel is lost or duplicated.
  - o_rgb is held while stalled, and i1_ready is 0 whenever o_valid && !o_ready.
- Source gaps: source 0 delivers 3 pixels, then drops valid for 5 cycles while source 1 is valid.
  - Required: the grant stays on G0 and i1_ready stays 0 until source 0 completes all 8 pixels.
- Reset mid-burst: assert rst after the 5th pixel of a G1 burst.
  - Required: o_valid drops asynchronously.
  - After release: the next grant follows prio = 0, and cnt restarts so o_first is set on the first new pixel.
